tx_symbol_source: RTL and testbench

Parametrised multi-lane symbol source for the transmitter chain, replacing the fixed PRBS9 I/Q pair at the head of the TX path. Each lane runs an independent PRBS LFSR of selectable order, maps bits to ±1 fixed-point symbols, and emits them zero-stuffed at OVERSAMP samples per baud, ready for the polyphase TX filter. Lane 0 is I and lane 1 is Q at the default configuration; further lanes serve multi-carrier tests.

---
 rtl/tx_src_pkg.sv | 45 ++++
 rtl/prbs_lfsr.sv | 59 +++++
 rtl/tx_symbol_source.sv | 144 ++++++++++++++
 tb/tb_tx_symbol_source.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_src_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_src_pkg
// Description : Shared constants and helpers for the TX symbol source:
//               PRBS tap lookup, legal LFSR orders and Q-format +/-1 values.
// Revision    : 1.0 - initial release
// ============================================================================
package tx_src_pkg;

   // LFSR orders that have a tap entry below
   localparam int c_num_orders = 5;
   localparam int c_legal_orders [c_num_orders] = '{7, 9, 15, 23, 31};

   // Default output fractional width and the matching +/-1.0 codes
   localparam int c_nbf_out_default = 6;
   localparam int c_q_plus_one      = 1 << c_nbf_out_default;
   localparam int c_q_minus_one     = -(1 << c_nbf_out_default);

   // Feedback tap T for a Fibonacci LFSR of order N (new = s[N-1] ^ s[T-1])
   function automatic int prbs_tap(input int order);
      case (order)
         7:       return 6;
         9:       return 5;
         15:      return 14;
         23:      return 18;
         31:      return 28;
         default: return 0;
      endcase
   endfunction

   // True when the order has a known maximal-length tap
   function automatic bit is_legal_order(input int order);
      for (int i = 0; i < c_num_orders; i++) begin
         if (c_legal_orders[i] == order) return 1'b1;
      end
      return 1'b0;
   endfunction

   // +1.0 in a format with nbf fractional bits
   function automatic int q_one(input int nbf);
      return 1 << nbf;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : prbs_lfsr
// Description : One Fibonacci PRBS lane. Loads SEED on reset or i_load,
//               shifts left by one on i_step and exposes the MSB, which is
//               the bit emitted before the step. An all-zero state is forced
//               to 1 on the next step so the lane can never lock up.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_lfsr
   import tx_src_pkg::*;
#(
   parameter int               ORDER = 9,
   parameter logic [ORDER-1:0] SEED  = {ORDER{1'b1}}
) (
   input  logic clk,
   input  logic i_reset,
   input  logic i_step,
   input  logic i_load,
   output logic o_msb
);

   localparam int c_tap = prbs_tap(ORDER);

   logic [ORDER-1:0] r_state;
   logic [ORDER-1:0] w_next;

   generate
      if (!is_legal_order(ORDER)) begin : g_bad_order
         $error("prbs_lfsr: ORDER %0d has no tap entry", ORDER);
      end
      if (SEED == '0) begin : g_zero_seed
         $error("prbs_lfsr: all-zero SEED would lock the LFSR");
      end
   endgenerate

   // Next state: one Fibonacci shift, with the lock-up escape
   always_comb begin
      w_next = {r_state[ORDER-2:0], r_state[ORDER-1] ^ r_state[c_tap-1]};
      if (r_state == '0) begin
         w_next = ORDER'(1);
      end
   end

   // State register: seed on reset/load, advance on step
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= SEED;
      end else if (i_load) begin
         r_state <= SEED;
      end else if (i_step) begin
         r_state <= w_next;
      end
   end

   assign o_msb = r_state[ORDER-1];

endmodule
`default_nettype wire

// File: rtl/tx_symbol_source.sv
`default_nettype none
// ============================================================================
// Module      : tx_symbol_source
// Description : Multi-lane PRBS symbol source. Each lane maps its bit to a
//               +/-1.0 fixed-point sample on phase 0 and zero-stuffs the
//               remaining OVERSAMP-1 phases. All outputs are registered.
//               Optional build macro TX_SRC_ERR_INJECT_EN adds i_err_inject
//               (inverts lane 0 on a symbol cycle) and o_err_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_symbol_source
   import tx_src_pkg::*;
#(
   parameter int                            NLANES     = 2,
   parameter int                            PRBS_ORDER = 9,
   parameter logic [NLANES*PRBS_ORDER-1:0]  SEEDS      = {9'h1FE, 9'h1AA},
   parameter int                            OVERSAMP   = 4,
   parameter int                            NBT_OUT    = 8,
   parameter int                            NBF_OUT    = 6
) (
   input  logic                          clk,
   input  logic                          i_reset,
   input  logic                          i_enable,
   input  logic                          i_seed_load,
`ifdef TX_SRC_ERR_INJECT_EN
   input  logic                          i_err_inject,
   output logic [15:0]                   o_err_count,
`endif
   output logic                          o_valid,
   output logic [$clog2(OVERSAMP)-1:0]   o_phase,
   output logic [NLANES-1:0]             o_bits,
   output logic [NLANES*NBT_OUT-1:0]     o_sym
);

   localparam int                 c_pw         = $clog2(OVERSAMP);
   localparam logic [c_pw-1:0]    c_last_phase = c_pw'(OVERSAMP - 1);
   localparam logic [NBT_OUT-1:0] c_sym_pos    = NBT_OUT'(q_one(NBF_OUT));
   localparam logic [NBT_OUT-1:0] c_sym_neg    = NBT_OUT'(-q_one(NBF_OUT));

   generate
      if (NLANES < 1 || NLANES > 8) begin : g_bad_nlanes
         $error("tx_symbol_source: NLANES must be 1..8");
      end
      if (OVERSAMP < 2) begin : g_bad_oversamp
         $error("tx_symbol_source: OVERSAMP must be at least 2");
      end
      if (NBT_OUT - NBF_OUT < 2) begin : g_bad_format
         $error("tx_symbol_source: need two integer bits to hold +/-1.0");
      end
   endgenerate

   logic [c_pw-1:0]           r_phase;
   logic [c_pw-1:0]           r_phase_out;
   logic                      r_valid;
   logic [NLANES-1:0]         r_bits;
   logic [NLANES*NBT_OUT-1:0] r_sym;

   logic [NLANES-1:0]         w_lane_bits;
   logic [NLANES-1:0]         w_bits_next;
   logic [NLANES*NBT_OUT-1:0] w_sym_next;
   logic                      w_sym_cycle;

   // A symbol is produced on enabled phase-0 cycles; seed load wins
   assign w_sym_cycle = i_enable & ~i_seed_load & (r_phase == '0);

   generate
      for (genvar k = 0; k < NLANES; k++) begin : g_lane
         prbs_lfsr #(
            .ORDER (PRBS_ORDER),
            .SEED  (SEEDS[k*PRBS_ORDER +: PRBS_ORDER])
         ) u_lfsr (
            .clk     (clk),
            .i_reset (i_reset),
            .i_step  (w_sym_cycle),
            .i_load  (i_seed_load),
            .o_msb   (w_lane_bits[k])
         );
      end
   endgenerate

   // Bit selection (with optional lane 0 inversion) and +/-1 mapping
   always_comb begin
      w_bits_next = w_lane_bits;
`ifdef TX_SRC_ERR_INJECT_EN
      w_bits_next[0] = w_lane_bits[0] ^ i_err_inject;
`endif
      w_sym_next = '0;
      for (int k = 0; k < NLANES; k++) begin
         w_sym_next[k*NBT_OUT +: NBT_OUT] = w_bits_next[k] ? c_sym_neg : c_sym_pos;
      end
   end

   // Phase counter and registered sample outputs
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         r_phase     <= '0;
         r_phase_out <= '0;
         r_valid     <= 1'b0;
         r_bits      <= '0;
         r_sym       <= '0;
      end else if (i_seed_load) begin
         r_phase     <= '0;
         r_phase_out <= '0;
         r_valid     <= 1'b0;
         r_sym       <= '0;
      end else if (i_enable) begin
         r_phase_out <= r_phase;
         r_phase     <= (r_phase == c_last_phase) ? '0 : r_phase + c_pw'(1);
         if (r_phase == '0) begin
            r_valid <= 1'b1;
            r_bits  <= w_bits_next;
            r_sym   <= w_sym_next;
         end else begin
            r_valid <= 1'b0;
            r_sym   <= '0;
         end
      end else begin
         r_valid <= 1'b0;
         r_sym   <= '0;
      end
   end

`ifdef TX_SRC_ERR_INJECT_EN
   logic [15:0] r_err_count;

   // Saturating count of injected symbol errors, cleared only by reset
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         r_err_count <= '0;
      end else if (w_sym_cycle && i_err_inject && (r_err_count != 16'hFFFF)) begin
         r_err_count <= r_err_count + 16'd1;
      end
   end

   assign o_err_count = r_err_count;
`endif

   assign o_valid = r_valid;
   assign o_phase = r_phase_out;
   assign o_bits  = r_bits;
   assign o_sym   = r_sym;

endmodule
`default_nettype wire

// File: tb/tb_tx_symbol_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_symbol_source
// Description : Self-checking bench for tx_symbol_source at default
//               parameters. A bit-level reference model pushes the expected
//               registered outputs for each driven cycle into a queue; each
//               scenario task pops and compares after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_symbol_source;

   localparam int              NL  = 2;
   localparam int              N   = 9;
   localparam int              OS  = 4;
   localparam int              NBT = 8;
   localparam logic [NL*N-1:0] c_seeds = {9'h1FE, 9'h1AA};

   typedef struct packed {
      logic          valid;
      logic [1:0]    phase;
      logic [NL-1:0] bits;
      logic [NL*NBT-1:0] sym;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              i_reset;
   logic              i_enable;
   logic              i_seed_load;
   logic              o_valid;
   logic [1:0]        o_phase;
   logic [NL-1:0]     o_bits;
   logic [NL*NBT-1:0] o_sym;
`ifdef TX_SRC_ERR_INJECT_EN
   logic              i_err_inject;
   logic [15:0]       o_err_count;
`endif

   tx_symbol_source #(
      .NLANES     (NL),
      .PRBS_ORDER (N),
      .SEEDS      (c_seeds),
      .OVERSAMP   (OS),
      .NBT_OUT    (NBT),
      .NBF_OUT    (6)
   ) dut (
      .clk          (clk),
      .i_reset      (i_reset),
      .i_enable     (i_enable),
      .i_seed_load  (i_seed_load),
`ifdef TX_SRC_ERR_INJECT_EN
      .i_err_inject (i_err_inject),
      .o_err_count  (o_err_count),
`endif
      .o_valid      (o_valid),
      .o_phase      (o_phase),
      .o_bits       (o_bits),
      .o_sym        (o_sym)
   );

   exp_t sb [$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model state
   logic [N-1:0]  m_state [NL];
   logic [1:0]    m_phase;
   logic [1:0]    m_ophase;
   logic [NL-1:0] m_bits;
   int            m_errcnt;

   function automatic void model_reset();
      for (int k = 0; k < NL; k++) m_state[k] = c_seeds[k*N +: N];
      m_phase  = 2'd0;
      m_ophase = 2'd0;
      m_bits   = '0;
      m_errcnt = 0;
   endfunction

   function automatic void model_push(input logic en, input logic load, input logic inj);
      exp_t   e;
      logic   b;
      logic   inj_eff;
`ifdef TX_SRC_ERR_INJECT_EN
      inj_eff = inj;
`else
      inj_eff = inj & 1'b0;
`endif
      e.valid = 1'b0;
      e.sym   = '0;
      if (load) begin
         for (int k = 0; k < NL; k++) m_state[k] = c_seeds[k*N +: N];
         m_phase  = 2'd0;
         m_ophase = 2'd0;
      end else if (en) begin
         m_ophase = m_phase;
         if (m_phase == 2'd0) begin
            for (int k = 0; k < NL; k++) begin
               b = m_state[k][N-1] ^ ((k == 0) ? inj_eff : 1'b0);
               m_bits[k] = b;
               e.sym[k*NBT +: NBT] = b ? 8'hC0 : 8'h40;
               if (m_state[k] == '0) m_state[k] = 9'd1;
               else m_state[k] = {m_state[k][N-2:0], m_state[k][8] ^ m_state[k][4]};
            end
            if (inj_eff && m_errcnt < 65535) m_errcnt++;
            e.valid = 1'b1;
         end
         m_phase = (m_phase == 2'd3) ? 2'd0 : m_phase + 2'd1;
      end
      e.phase = m_ophase;
      e.bits  = m_bits;
      sb.push_back(e);
   endfunction

   // Drive one cycle of stimulus, record the expectation, sample after the edge
   task automatic clock(input logic en, input logic load, input logic inj);
      i_enable    = en;
      i_seed_load = load;
`ifdef TX_SRC_ERR_INJECT_EN
      i_err_inject = inj;
`endif
      model_push(en, load, inj);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      i_reset = 1'b0; i_enable = 1'b0; i_seed_load = 1'b0;
`ifdef TX_SRC_ERR_INJECT_EN
      i_err_inject = 1'b0;
`endif
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
      n_vec++; if (o_phase !== 2'd0) begin n_err++; $display("FAIL reset_phase: got %0d expected 0", o_phase); end
      n_vec++; if (o_bits !== 2'b00) begin n_err++; $display("FAIL reset_bits: got %b expected 00", o_bits); end
      n_vec++; if (o_sym !== 16'h0000) begin n_err++; $display("FAIL reset_sym: got %h expected 0000", o_sym); end
`ifdef TX_SRC_ERR_INJECT_EN
      n_vec++; if (o_err_count !== 16'd0) begin n_err++; $display("FAIL reset_errcnt: got %0d expected 0", o_err_count); end
`endif
      i_reset = 1'b1;
      e = '0;
      e.valid = 1'b0;
   endtask

   task automatic test_first_symbols();
      exp_t e;
      logic [7:0] lane0 [$];
      for (int c = 0; c < 12; c++) begin
         clock(1'b1, 1'b0, 1'b0);
         e = sb.pop_front();
         n_vec++;
         if ({o_valid, o_phase, o_bits, o_sym} !== e) begin
            n_err++;
            $display("FAIL first_sym cyc %0d: got %h expected %h", c, {o_valid, o_phase, o_bits, o_sym}, e);
         end
         if (o_valid) lane0.push_back(o_sym[7:0]);
         n_vec++;
         if (o_valid !== (c % 4 == 0)) begin
            n_err++;
            $display("FAIL valid_duty cyc %0d: got %b expected %b", c, o_valid, (c % 4 == 0));
         end
      end
      n_vec++;
      if (lane0.size() != 3 || lane0[0] !== 8'hC0 || lane0[1] !== 8'hC0 || lane0[2] !== 8'h40) begin
         n_err++;
         $display("FAIL first_three_lane0: got %p expected -64,-64,+64", lane0);
      end
   endtask

   task automatic test_period();
      exp_t e;
      logic [NL-1:0] hist [$];
      int ones, diffs;
      for (int c = 0; c < 5000 && hist.size() < 1022; c++) begin
         clock(1'b1, 1'b0, 1'b0);
         e = sb.pop_front();
         n_vec++;
         if ({o_valid, o_phase, o_bits, o_sym} !== e) begin
            n_err++;
            $display("FAIL period_cycle %0d: got %h expected %h", c, {o_valid, o_phase, o_bits, o_sym}, e);
         end
         if (o_valid) hist.push_back(o_bits);
      end
      n_vec++;
      if (hist.size() != 1022) begin
         n_err++;
         $display("FAIL period_budget: got %0d symbols expected 1022", hist.size());
      end else begin
         for (int k = 0; k < NL; k++) begin
            ones = 0; diffs = 0;
            for (int i = 0; i < 511; i++) begin
               ones += int'(hist[i][k]);
               if (hist[i][k] !== hist[i+511][k]) diffs++;
            end
            n_vec++;
            if (ones != 256) begin n_err++; $display("FAIL period_ones lane %0d: got %0d expected 256", k, ones); end
            n_vec++;
            if (diffs != 0) begin n_err++; $display("FAIL period_repeat lane %0d: got %0d diffs expected 0", k, diffs); end
         end
      end
   endtask

   task automatic test_enable_gap();
      exp_t e;
      bit   found = 0;
      for (int c = 0; c < 8 && !found; c++) begin
         clock(1'b1, 1'b0, 1'b0);
         e = sb.pop_front();
         n_vec++;
         if ({o_valid, o_phase, o_bits, o_sym} !== e) begin
            n_err++; $display("FAIL gap_pre: got %h expected %h", {o_valid, o_phase, o_bits, o_sym}, e);
         end
         if (o_phase == 2'd2) found = 1;
      end
      n_vec++;
      if (!found) begin n_err++; $display("FAIL gap_find_phase2: got none expected phase 2 within 8 cycles"); end
      for (int c = 0; c < 5; c++) begin
         clock(1'b0, 1'b0, 1'b0);
         e = sb.pop_front();
         n_vec++;
         if ({o_valid, o_phase, o_bits, o_sym} !== e) begin
            n_err++; $display("FAIL gap_hold %0d: got %h expected %h", c, {o_valid, o_phase, o_bits, o_sym}, e);
         end
      end
      clock(1'b1, 1'b0, 1'b0);
      e = sb.pop_front();
      n_vec++;
      if (o_phase !== 2'd3) begin n_err++; $display("FAIL gap_resume_phase: got %0d expected 3", o_phase); end
      for (int c = 0; c < 4; c++) begin
         clock(1'b1, 1'b0, 1'b0);
         e = sb.pop_front();
         n_vec++;
         if ({o_valid, o_phase, o_bits, o_sym} !== e) begin
            n_err++; $display("FAIL gap_post %0d: got %h expected %h", c, {o_valid, o_phase, o_bits, o_sym}, e);
         end
      end
   endtask

   task automatic test_seed_load();
      exp_t e;
      bit   found = 0;
      logic b0 [$];
      for (int c = 0; c < 8 && !found; c++) begin
         clock(1'b1, 1'b0, 1'b0);
         e = sb.pop_front();
         if (o_phase == 2'd1) found = 1;
      end
      n_vec++;
      if (!found) begin n_err++; $display("FAIL load_find_phase1: got none expected phase 1 within 8 cycles"); end
      clock(1'b1, 1'b1, 1'b0);
      e = sb.pop_front();
      n_vec++;
      if ({o_valid, o_phase, o_sym} !== {1'b0, 2'd0, 16'h0000}) begin
         n_err++; $display("FAIL load_cycle: got v=%b ph=%0d sym=%h expected v=0 ph=0 sym=0000", o_valid, o_phase, o_sym);
      end
      for (int c = 0; c < 12; c++) begin
         clock(1'b1, 1'b0, 1'b0);
         e = sb.pop_front();
         n_vec++;
         if ({o_valid, o_phase, o_bits, o_sym} !== e) begin
            n_err++; $display("FAIL load_replay %0d: got %h expected %h", c, {o_valid, o_phase, o_bits, o_sym}, e);
         end
         if (o_valid) b0.push_back(o_bits[0]);
      end
      n_vec++;
      if (b0.size() != 3 || b0[0] !== 1'b1 || b0[1] !== 1'b1 || b0[2] !== 1'b0) begin
         n_err++; $display("FAIL load_lane0_bits: got %p expected 1,1,0", b0);
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      bit   found = 0;
      logic b0 [$];
      for (int c = 0; c < 8 && !found; c++) begin
         clock(1'b1, 1'b0, 1'b0);
         e = sb.pop_front();
         if (o_valid) found = 1;
      end
      n_vec++;
      if (!found) begin n_err++; $display("FAIL areset_find_valid: got none expected a valid within 8 cycles"); end
      #3 i_reset = 1'b0;
      #1;
      n_vec++;
      if (o_valid !== 1'b0 || o_sym !== 16'h0000) begin
         n_err++; $display("FAIL areset_immediate: got v=%b sym=%h expected v=0 sym=0000", o_valid, o_sym);
      end
      sb.delete();
      model_reset();
      #10 i_reset = 1'b1;
      for (int c = 0; c < 12; c++) begin
         clock(1'b1, 1'b0, 1'b0);
         e = sb.pop_front();
         n_vec++;
         if ({o_valid, o_phase, o_bits, o_sym} !== e) begin
            n_err++; $display("FAIL areset_restart %0d: got %h expected %h", c, {o_valid, o_phase, o_bits, o_sym}, e);
         end
         if (o_valid) b0.push_back(o_bits[0]);
      end
      n_vec++;
      if (b0.size() != 3 || b0[0] !== 1'b1 || b0[1] !== 1'b1 || b0[2] !== 1'b0) begin
         n_err++; $display("FAIL areset_lane0_bits: got %p expected 1,1,0", b0);
      end
   endtask

`ifdef TX_SRC_ERR_INJECT_EN
   task automatic test_err_inject();
      exp_t e;
      for (int c = 0; c < 4 && m_phase != 2'd0; c++) begin
         clock(1'b1, 1'b0, 1'b0);
         e = sb.pop_front();
      end
      clock(1'b1, 1'b0, 1'b1);
      e = sb.pop_front();
      n_vec++;
      if ({o_valid, o_phase, o_bits, o_sym} !== e) begin
         n_err++; $display("FAIL inject_symbol: got %h expected %h", {o_valid, o_phase, o_bits, o_sym}, e);
      end
      n_vec++;
      if (o_err_count !== 16'd1) begin n_err++; $display("FAIL inject_count: got %0d expected 1", o_err_count); end
      for (int c = 0; c < 16; c++) begin
         clock(1'b1, 1'b0, 1'b0);
         e = sb.pop_front();
         n_vec++;
         if ({o_valid, o_phase, o_bits, o_sym} !== e) begin
            n_err++; $display("FAIL inject_after %0d: got %h expected %h", c, {o_valid, o_phase, o_bits, o_sym}, e);
         end
      end
      n_vec++;
      if (o_err_count !== 16'(m_errcnt)) begin
         n_err++; $display("FAIL inject_count_hold: got %0d expected %0d", o_err_count, m_errcnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_first_symbols();
      test_period();
      test_enable_gap();
      test_seed_load();
      test_async_reset();
`ifdef TX_SRC_ERR_INJECT_EN
      test_err_inject();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
